sync_fifo_v2: RTL and testbench

Parametrised successor to the single-clock buffer FIFO used throughout the memory controller. It adds the following over the existing FIFO:
- non-power-of-two depth;
- selectable output mode: registered-on-pop or first-word-fall-through (FWFT);
- programmable almost-full and almost-empty flags;
- synchronous flush;
- sticky overflow and underflow error flags.

It sits between the DRAM/GLB fetch logic and the PE array feeders as the default staging buffer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr_wrap.sv | 41 ++++
 rtl/sync_fifo_v2.sv | 117 +++++++++++
 tb/tb_sync_fifo_v2.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous staging FIFO.
// Output-mode selectors and a constant-foldable ceil(log2) helper.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer for the staging FIFO.
// Wraps explicitly at DEPTH-1 so non-power-of-two depths work.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock staging FIFO: any depth, std or FWFT output,
// programmable almost flags, flush and sticky error flags.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = clog2(DEPTH + 1),
    parameter int PTR_W      = clog2(DEPTH),
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  ovf_q;
    logic                  unf_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovf_set;
    logic                  unf_set;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign almost_empty = (cnt_q <= CNT_W'(AE_THRESH));
    assign almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
    assign fifo_count   = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A pop in the same cycle frees the slot, so push at full is legal then
    assign push_ok = push & ~flush & (~full | pop);
    assign pop_ok  = pop & ~flush & ~empty;
    assign ovf_set = push & ~flush & full & ~pop;
    assign unf_set = pop & ~flush & empty & ~push;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    fifo_ptr_wrap #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr_wrap #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (pop_ok) begin
                dout_q <= mem_q[rd_ptr];
            end
            ovf_q <= (ovf_q & ~clr_err) | ovf_set;
            unf_q <= (unf_q & ~clr_err) | unf_set;
        end
    end

    // FWFT shows the head word; when empty both modes show the last pop
    assign data_out = ((FWFT != FIFO_MODE_STD) && !empty) ?
                      mem_q[rd_ptr] : dout_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: std and FWFT instances share stimulus
// and are compared against a queue-based reference model.
module tb_sync_fifo_v2;

    localparam int DW = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          clr_err;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [2:0]    s_cnt, f_cnt;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_unf;
    int            vectors;
    int            errors;

    always #5 clk = ~clk;

    sync_fifo_v2 #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .FWFT       (0),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) u_std (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .push         (push),
        .data_in      (din),
        .pop          (pop),
        .data_out     (s_dout),
        .empty        (s_empty),
        .full         (s_full),
        .almost_empty (s_ae),
        .almost_full  (s_af),
        .fifo_count   (s_cnt),
        .overflow     (s_ovf),
        .underflow    (s_unf)
    );

    sync_fifo_v2 #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .FWFT       (1),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .push         (push),
        .data_in      (din),
        .pop          (pop),
        .data_out     (f_dout),
        .empty        (f_empty),
        .full         (f_full),
        .almost_empty (f_ae),
        .almost_full  (f_af),
        .fifo_count   (f_cnt),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Applies the FIFO rules to the inputs present at this clock edge
    task automatic model_edge();
        int  n;
        bit  vo;
        bit  vu;
        if (rst_n) begin
            model_reset();
            return;
        end
        n  = q.size();
        vo = 1'b0;
        vu = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            vo = push && (n == D) && !pop;
            vu = pop && (n == 0) && !push;
            if (pop && n > 0) m_dout = q.pop_front();
            if (push && (n < D || pop)) q.push_back(din);
        end
        m_ovf = (m_ovf && !clr_err) || vo;
        m_unf = (m_unf && !clr_err) || vu;
    endtask

    task automatic check_all();
        int            n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : m_dout;
        check("s_cnt", s_cnt, n);
        check("f_cnt", f_cnt, n);
        check("s_empty", s_empty, n == 0);
        check("f_empty", f_empty, n == 0);
        check("s_full", s_full, n == D);
        check("f_full", f_full, n == D);
        check("s_ae", s_ae, n <= AE);
        check("f_ae", f_ae, n <= AE);
        check("s_af", s_af, n >= AF);
        check("f_af", f_af, n >= AF);
        check("s_ovf", s_ovf, m_ovf);
        check("f_ovf", f_ovf, m_ovf);
        check("s_unf", s_unf, m_unf);
        check("f_unf", f_unf, m_unf);
        check("s_dout", s_dout, m_dout);
        check("f_dout", f_dout, head);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit ps, input bit pp,
                         input logic [DW-1:0] d,
                         input bit fl = 1'b0,
                         input bit ce = 1'b0);
        push    = ps;
        pop     = pp;
        din     = d;
        flush   = fl;
        clr_err = ce;
        step();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b1;
        flush   = 1'b0;
        clr_err = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        din     = '0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b0;

        // Fill and drain with threshold crossings
        for (int i = 1; i <= 5; i++) drive(1, 0, DW'(8'h11 * i));
        check("t1_cnt", s_cnt, 5);
        check("t1_full", s_full, 1);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, '0);
            check("t1_dout", s_dout, 8'h11 * i);
        end
        check("t1_empty", s_empty, 1);

        // Pointer wrap
        for (int i = 0; i < 3; i++) drive(1, 0, DW'(i + 1));
        for (int i = 0; i < 3; i++) drive(0, 1, '0);
        for (int i = 0; i < 5; i++) drive(1, 0, DW'(8'hA0 + i));
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, '0);
            check("t2_dout", s_dout, 8'hA0 + i);
        end

        // Full / empty edges
        for (int i = 0; i < 5; i++) drive(1, 0, DW'(8'hC0 + i));
        drive(1, 0, 8'hEE);
        check("t3_ovf", s_ovf, 1);
        check("t3_cnt", s_cnt, 5);
        drive(1, 1, 8'hEE);
        check("t3_cnt_pp", s_cnt, 5);
        drive(0, 0, '0, 0, 1);
        check("t3_clr", s_ovf, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, '0);
        check("t3_ee", s_dout, 8'hEE);
        drive(1, 1, 8'h77);
        check("t3_cnt1", s_cnt, 1);
        check("t3_unf", s_unf, 0);
        drive(0, 1, '0);

        // FWFT visibility
        drive(1, 0, 8'h5A);
        check("t4_vis", f_dout, 8'h5A);
        check("t4_ne", f_empty, 0);
        drive(0, 1, '0);
        check("t4_empty", f_empty, 1);
        check("t4_hold", f_dout, 8'h5A);

        // Flush with push
        for (int i = 0; i < 3; i++) drive(1, 0, DW'(8'h30 + i));
        drive(1, 0, 8'h99, 1);
        check("t5_cnt", s_cnt, 0);
        check("t5_ovf", s_ovf, 0);
        drive(1, 0, 8'h42);
        drive(0, 1, '0);
        check("t5_dout", s_dout, 8'h42);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) drive(1, 0, DW'(8'h60 + i));
        push = 1'b1;
        din  = 8'h70;
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all();
        check("t6_cnt", s_cnt, 0);
        step();
        rst_n = 1'b0;
        drive(0, 0, '0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) == 0);
            drive(1'($urandom), 1'($urandom), DW'($urandom),
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 15) == 0);
        end
        rst_n = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
